// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined shifter used in the square-root datapath.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_RSV = 2'b11
  } shift_mode_e;

  function automatic int shw_f(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 stage of the shifter: shift by 2^STAGE when the matching amount bit is set, then register.
// Optional sticky tracking is built only when PIPE_SHIFTER_STICKY_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 17,
  parameter  int STAGE = 0,
  localparam int SHW   = shw_f(WIDTH),
  localparam int S     = 1 << STAGE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
`ifdef PIPE_SHIFTER_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  shift_mode_e      mode_i,
  input  logic             sign_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output shift_mode_e      mode_o,
  output logic             sign_o
);

  logic             w_take;
  logic             w_right;
  logic             w_fill;
  logic [WIDTH-1:0] w_shifted;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_amt;
  shift_mode_e      r_mode;
  logic             r_sign;

  // Reserved mode falls through to a left shift; ASR fill comes from the sign captured at input.
  always_comb begin
    w_take    = amt_i[STAGE];
    w_right   = (mode_i == MODE_LSR) || (mode_i == MODE_ASR);
    w_fill    = (mode_i == MODE_ASR) && sign_i;
    w_shifted = data_i;
    if (w_take) begin
      if (w_right) w_shifted = {{S{w_fill}}, data_i[WIDTH-1:S]};
      else         w_shifted = {data_i[WIDTH-1-S:0], {S{1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= MODE_LSL;
      r_sign  <= 1'b0;
    end else if (en_i) begin
      r_valid <= valid_i;
      r_data  <= w_shifted;
      r_amt   <= amt_i;
      r_mode  <= mode_i;
      r_sign  <= sign_i;
    end
  end

`ifdef PIPE_SHIFTER_STICKY_EN
  logic w_lost;
  logic r_sticky;

  // Bits falling off the end this stage are folded into the running sticky flag.
  always_comb begin
    w_lost = 1'b0;
    if (w_take) begin
      if (w_right) w_lost = |data_i[S-1:0];
      else         w_lost = |data_i[WIDTH-1:WIDTH-S];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_sticky <= 1'b0;
    else if (en_i) r_sticky <= sticky_i | w_lost;
  end

  assign sticky_o = r_sticky;
`endif

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign amt_o   = r_amt;
  assign mode_o  = r_mode;
  assign sign_o  = r_sign;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined run-time shifter (LSL/LSR/ASR) with a global-stall valid/ready handshake.
// Define PIPE_SHIFTER_STICKY_EN to build the shifted-out sticky flag; otherwise sticky_o is 0.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 17,
  localparam int SHW   = shw_f(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SHW-1:0]   in_amt_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             sticky_o
);

  logic             w_advance;
  logic             w_valid  [0:SHW];
  logic [WIDTH-1:0] w_data   [0:SHW];
  logic [SHW-1:0]   w_amt    [0:SHW];
  shift_mode_e      w_mode   [0:SHW];
  logic             w_sign   [0:SHW];

  // The whole pipe moves together: it only stalls when a finished result is not taken.
  assign w_advance = ~out_valid_o | out_ready_i;
  assign in_ready_o = w_advance;

  assign w_valid[0] = in_valid_i;
  assign w_data[0]  = in_data_i;
  assign w_amt[0]   = in_amt_i;
  assign w_mode[0]  = shift_mode_e'(in_mode_i);
  assign w_sign[0]  = in_data_i[WIDTH-1];

`ifdef PIPE_SHIFTER_STICKY_EN
  logic w_sticky [0:SHW];
  assign w_sticky[0] = 1'b0;
  assign sticky_o    = w_sticky[SHW];
`else
  assign sticky_o = 1'b0;
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (w_advance),
`ifdef PIPE_SHIFTER_STICKY_EN
      .sticky_i (w_sticky[k]),
      .sticky_o (w_sticky[k+1]),
`endif
      .valid_i  (w_valid[k]),
      .data_i   (w_data[k]),
      .amt_i    (w_amt[k]),
      .mode_i   (w_mode[k]),
      .sign_i   (w_sign[k]),
      .valid_o  (w_valid[k+1]),
      .data_o   (w_data[k+1]),
      .amt_o    (w_amt[k+1]),
      .mode_o   (w_mode[k+1]),
      .sign_o   (w_sign[k+1])
    );
  end

  assign out_valid_o = w_valid[SHW];
  assign out_data_o  = w_data[SHW];

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter at WIDTH=17 (latency 5).
module tb_pipe_shifter;

  localparam int WIDTH = 17;
  localparam int SHW   = 5;
`ifdef PIPE_SHIFTER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic [SHW-1:0]   inAmt;
  logic [1:0]       inMode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic             sticky;

  int errorCount = 0;
  int checkCount = 0;

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .in_amt_i    (inAmt),
    .in_mode_i   (inMode),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .sticky_o    (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                               input logic [1:0] m);
    inValid = v;
    inData  = d;
    inAmt   = a;
    inMode  = m;
  endtask

  // One beat into an empty pipe; latency counts clock edges from the accepting edge onward.
  task automatic runBeat(input string tag, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                         input logic [1:0] m, input logic [WIDTH-1:0] expData, input logic expSticky);
    int cyc;
    @(negedge clk);
    outReady = 1'b1;
    applyStimulus(1'b1, d, a, m);
    #1;
    checkOutput({tag, "_ready"}, inReady, 1);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      inValid = 1'b0;
    end while (!outValid && cyc < 20);
    checkOutput({tag, "_latency"}, cyc, 5);
    checkOutput({tag, "_data"}, outData, expData);
    checkOutput({tag, "_sticky"}, sticky, expSticky & STICKY_ON);
  endtask

  initial begin
    int sent;
    int recv;
    int firstCyc;
    int lastCyc;
    int staleSeen;
    logic willAccept;

    rst      = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'b00);
    #1;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_data", outData, 0);
    checkOutput("rst_sticky", sticky, 0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_inready", inReady, 1);

    runBeat("lsl1",     17'h000FF, 5'd1,  2'b00, 17'h001FE, 1'b0);
    runBeat("lsr16",    17'h10000, 5'd16, 2'b01, 17'h00001, 1'b0);
    runBeat("asr4",     17'h10000, 5'd4,  2'b10, 17'h1F000, 1'b0);
    runBeat("rsv3",     17'h00001, 5'd3,  2'b11, 17'h00008, 1'b0);
    runBeat("lsl20",    17'h1FFFF, 5'd20, 2'b00, 17'h00000, 1'b1);
    runBeat("asr20",    17'h1FFFF, 5'd20, 2'b10, 17'h1FFFF, 1'b1);
    runBeat("lsr1",     17'h00003, 5'd1,  2'b01, 17'h00001, 1'b1);
    runBeat("amt0",     17'h12345, 5'd0,  2'b01, 17'h12345, 1'b0);
    runBeat("lsr31",    17'h1FFFF, 5'd31, 2'b01, 17'h00000, 1'b1);
    runBeat("asr17pos", 17'h0FFFF, 5'd17, 2'b10, 17'h00000, 1'b1);

    // Back-to-back stream: beat i is 0x101 << i.
    sent = 0; recv = 0; firstCyc = -1; lastCyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      outReady = 1'b1;
      if (outValid) begin
        checkOutput($sformatf("stream_%0d", recv), outData, 17'h00101 << recv);
        if (firstCyc < 0) firstCyc = c;
        lastCyc = c;
        recv++;
      end
      if (sent < 8) begin
        applyStimulus(1'b1, 17'h00101, SHW'(sent), 2'b00);
        sent++;
      end else begin
        inValid = 1'b0;
      end
    end
    checkOutput("stream_count", recv, 8);
    checkOutput("stream_span", lastCyc - firstCyc, 7);

    // Backpressure: fill with out_ready low, hold 3 cycles, then drain.
    sent = 0; recv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      outReady = (c >= 8);
      if (sent < 8) applyStimulus(1'b1, 17'h00100 + 17'(sent), '0, 2'b00);
      else          inValid = 1'b0;
      #1;
      if (c >= 5 && c < 8) begin
        checkOutput($sformatf("stall_inready_%0d", c), inReady, 0);
        checkOutput($sformatf("stall_hold_%0d", c), outData, 17'h00100);
      end
      if (outValid && outReady) begin
        checkOutput($sformatf("drain_%0d", recv), outData, 17'h00100 + 17'(recv));
        recv++;
      end
      willAccept = inValid && inReady;
      @(posedge clk);
      if (willAccept) sent++;
    end
    checkOutput("drain_count", recv, 8);

    // Reset with a full, stalled pipe: results vanish immediately and never reappear.
    @(negedge clk);
    outReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 17'h000AA + 17'(c), '0, 2'b00);
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("prereset_valid", outValid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", outValid, 0);
    checkOutput("midrst_data", outData, 0);
    @(negedge clk);
    rst = 1'b0;
    outReady = 1'b1;
    staleSeen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (outValid) staleSeen++;
    end
    checkOutput("postrst_stale", staleSeen, 0);
    runBeat("postrst", 17'h00055, 5'd2, 2'b00, 17'h00154, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
